// File: rtl/xgriscv_muldiv.sv
// Iterative RV32M/RV64M multiply/divide unit: shift-add multiply, restoring divide,
// UNROLL bits per cycle. Optional macro MULDIV_EARLY_OUT_EN skips CALC for trivial operands.
module xgriscv_muldiv #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned UNROLL = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start_i,
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  input  logic            flush_i,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o
);

  localparam int unsigned N    = XLEN / UNROLL;
  localparam int unsigned CntW = $clog2(N + 1);
  localparam logic [XLEN-1:0] MinVal = {1'b1, {(XLEN - 1){1'b0}}};

  typedef enum logic [1:0] {StIdle, StCalc, StFix, StDone} state_e;

  state_e state_q, state_d;

  logic [2:0]      op_q, op_d;
  logic            neg_q, neg_d;
  logic [XLEN:0]   dvsr_q, dvsr_d;  // multiplicand or divisor magnitude
  logic [XLEN:0]   hi_q, hi_d;      // product high half / partial remainder
  logic [XLEN-1:0] lo_q, lo_d;      // multiplier -> product low / dividend -> quotient
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0] result_q, result_d;

  // Operand decode at start
  logic            is_div, a_signed, b_signed, sa, sb, b_zero, div_ovf, early, skip, start_ok;
  logic [XLEN-1:0] a_mag, b_mag;

  assign is_div   = op_i[2];
  assign a_signed = is_div ? ~op_i[0] : (op_i[1:0] != 2'b11);
  assign b_signed = is_div ? ~op_i[0] : ~op_i[1];
  assign sa       = a_signed & a_i[XLEN-1];
  assign sb       = b_signed & b_i[XLEN-1];
  assign a_mag    = sa ? -a_i : a_i;
  assign b_mag    = sb ? -b_i : b_i;
  assign b_zero   = (b_i == '0);
  assign div_ovf  = is_div & ~op_i[0] & (a_i == MinVal) & (b_i == '1);
`ifdef MULDIV_EARLY_OUT_EN
  logic early_mul, early_div;
  assign early_mul = ~is_div & ((a_i == '0) | b_zero);
  assign early_div = is_div & ~b_zero & ~div_ovf & (a_mag < b_mag);
  assign early     = early_mul | early_div;
`else
  assign early     = 1'b0;
`endif
  assign skip     = (is_div & b_zero) | div_ovf | early;
  assign start_ok = start_i & ~flush_i & ((state_q == StIdle) | (state_q == StDone));

  // FSM: state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= StIdle;
    else        state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle, StDone: state_d = start_ok ? (skip ? StFix : StCalc) : StIdle;
      StCalc:         if (cnt_q == CntW'(N - 1)) state_d = StFix;
      StFix:          state_d = StDone;
      default:        state_d = StIdle;
    endcase
    if (flush_i) state_d = StIdle;
  end

  // FSM: outputs
  always_comb begin
    busy_o = (state_q == StCalc) | (state_q == StFix);
    done_o = (state_q == StDone);
  end

  // One CALC cycle: UNROLL shift-add or restoring-divide steps
  logic [XLEN:0]   calc_hi;
  logic [XLEN-1:0] calc_lo;

  always_comb begin
    logic [XLEN:0]   h, rs, sum;
    logic [XLEN-1:0] l;
    logic [XLEN+1:0] diff;
    h = hi_q;
    l = lo_q;
    rs = '0;
    sum = '0;
    diff = '0;
    for (int i = 0; i < UNROLL; i++) begin
      if (op_q[2]) begin
        rs   = {h[XLEN-1:0], l[XLEN-1]};
        diff = {1'b0, rs} - {1'b0, dvsr_q};
        if (!diff[XLEN+1]) begin
          h = diff[XLEN:0];
          l = {l[XLEN-2:0], 1'b1};
        end else begin
          h = rs;
          l = {l[XLEN-2:0], 1'b0};
        end
      end else begin
        sum = h + (l[0] ? dvsr_q : '0);
        l   = {sum[0], l[XLEN-1:1]};
        h   = {1'b0, sum[XLEN:1]};
      end
    end
    calc_hi = h;
    calc_lo = l;
  end

  // FIX: sign correction and half/quotient/remainder selection
  logic [2*XLEN-1:0] product, prod_fix;
  logic [XLEN-1:0]   div_raw, div_res, mul_res, fix_res;

  always_comb begin
    product  = {hi_q[XLEN-1:0], lo_q};
    prod_fix = neg_q ? -product : product;
    mul_res  = (op_q[1:0] == 2'b00) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
    div_raw  = op_q[1] ? hi_q[XLEN-1:0] : lo_q;
    div_res  = neg_q ? -div_raw : div_raw;
    fix_res  = op_q[2] ? div_res : mul_res;
  end

  // Datapath next state
  always_comb begin
    op_d     = op_q;
    neg_d    = neg_q;
    dvsr_d   = dvsr_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    if (start_ok) begin
      op_d   = op_i;
      cnt_d  = '0;
      neg_d  = (is_div & op_i[1]) ? sa : (sa ^ sb);
      dvsr_d = is_div ? {1'b0, b_mag} : {1'b0, a_mag};
      hi_d   = '0;
      lo_d   = is_div ? a_mag : b_mag;
      if (is_div & b_zero) begin
        lo_d  = '1;
        hi_d  = {1'b0, a_i};
        neg_d = 1'b0;
      end else if (div_ovf) begin
        lo_d  = a_i;
        hi_d  = '0;
        neg_d = 1'b0;
      end
`ifdef MULDIV_EARLY_OUT_EN
      else if (early_mul) begin
        lo_d = '0;
        hi_d = '0;
      end else if (early_div) begin
        lo_d = '0;
        hi_d = {1'b0, a_mag};
      end
`endif
    end else if (state_q == StCalc) begin
      hi_d  = calc_hi;
      lo_d  = calc_lo;
      cnt_d = cnt_q + 1'b1;
    end else if ((state_q == StFix) && !flush_i) begin
      result_d = fix_res;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op_q     <= '0;
      neg_q    <= 1'b0;
      dvsr_q   <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      op_q     <= op_d;
      neg_q    <= neg_d;
      dvsr_q   <= dvsr_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
    end
  end

  assign result_o = result_q;

endmodule

// File: doc/xgriscv_muldiv.md
Name: xgriscv_muldiv

Overview:
Iterative multiply/divide unit for the RV32M/RV64M instructions. It sits beside the ALU in the EX stage of the pipeline. It accepts one operation per start pulse, computes over several cycles while holding busy_o high, which the hazard logic uses to stall IF/ID/EX, and returns the result with a one-cycle done_o pulse. Width and bits-per-cycle are parameters; the current fixed-latency ALU has neither.

Parameters:
XLEN, 32, operand/result width; must be 32 or 64.
UNROLL, 1, quotient/product bits retired per CALC cycle; must divide XLEN (1, 2, 4).

Ports:
clk  in  1  clock; all state updates on rising edge.
reset  in  1  asynchronous, active-low reset.
start_i  in  1  request; sampled only in IDLE or DONE.
op_i  in  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
a_i  in  XLEN  rs1 operand (srcA).
b_i  in  XLEN  rs2 operand (srcB).
flush_i  in  1  abort the current operation (branch/jump flush).
busy_o  out  1  high in CALC and FIX; drives the pipeline stall.
done_o  out  1  one-cycle pulse; result_o is valid in that cycle.
result_o  out  XLEN  result; held until the next accepted start.

Behaviour:
- Reset (reset==0, async): state=IDLE; busy_o=0, done_o=0, result_o=0; all internal registers cleared. Reset during any state aborts with no done_o.
- FSM states: IDLE, CALC, FIX, DONE.
- IDLE/DONE with start_i=1 and flush_i=0: latch op_i; latch |a_i| and |b_i| per signedness (MULH/DIV/REM signed both; MULHSU a signed only; MULHU/DIVU/REMU/MUL unsigned magnitudes with MUL sign-corrected); record the result sign; clear the counter; go to CALC.
- Special divide cases are detected at start and skip CALC, going directly to FIX:
  - b==0: DIV/DIVU quotient = all ones; REM/REMU = a.
  - Signed overflow (a = most negative value, b = -1, DIV/REM only): quotient = a; remainder = 0.
- CALC: N = XLEN/UNROLL cycles.
  - Multiply: shift-add of UNROLL multiplier bits per cycle into a 2*XLEN accumulator.
  - Divide: restoring subtract-shift, UNROLL quotient bits per cycle.
  - The counter runs 0..N-1; on the last count, go to FIX.
- FIX (1 cycle): apply two's-complement sign correction.
  - Select the low half for MUL, the high half for MULH/MULHSU/MULHU.
  - Quotient sign = sign(a) XOR sign(b); remainder sign = sign(a).
  - Register the result into result_o; go to DONE.
- DONE (1 cycle): done_o=1. A start_i in this cycle is accepted (back-to-back); otherwise go to IDLE.
- Latency: start accepted at cycle 0 → done_o at cycle N+2. For special cases, done_o at cycle 2.
- busy_o is a registered state decode: 1 exactly in CALC/FIX. start_i while busy_o=1 is ignored.
- flush_i=1 in any state: next state IDLE, no done_o, result_o unchanged. flush_i and start_i together: flush wins, start is dropped.
- Arithmetic: all internal magnitudes are XLEN+1 bits. Results wrap modulo 2^XLEN. No exceptions are raised.

Optional Feature:
MULDIV_EARLY_OUT_EN:
- When defined: a multiply with a==0 or b==0, or a divide with |a| < |b| (and b!=0), skips CALC. The unit goes to FIX with product=0, or quotient=0 and remainder=a. done_o fires at cycle 2.
- When undefined: these cases take the full N+2 cycles with identical results.

Test Plan:
1. XLEN=32, UNROLL=1: MUL a=7, b=0xFFFFFFFD → result_o=0xFFFFFFEB; busy_o high cycles 1–33; done_o exactly at cycle 34.
2. MULH 0x80000000×0x80000000 → 0x40000000. MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE. MULHSU a=0xFFFFFFFF, b=0xFFFFFFFF → 0xFFFFFFFF.
3. DIV -7/2 → 0xFFFFFFFD. REM -7/2 → 0xFFFFFFFF. DIVU 100/7 → 14. REMU 100/7 → 2. With UNROLL=4, done_o at cycle 10.
4. DIV 5/0 → 0xFFFFFFFF; REM 5/0 → 5; DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM of the same → 0. Each has done_o at cycle 2.
5. Start DIVU at cycle 0, flush_i at cycle 10 → busy_o=0 at cycle 11, no done_o, result_o unchanged. A new start at cycle 11 completes normally at cycle 45.
6. reset driven low at cycle 15 of a MUL → busy_o, done_o and result_o are 0 immediately (asynchronously). Release reset, then issue back-to-back starts, the second in the DONE cycle → two done_o pulses N+2 cycles apart.
